// File: rtl/ab_gen_pkg.sv
// ab_pkg: shared definitions for the address-bus generator.
//   - base select codes (op[3:2]) and offset select codes (op[1:0])
//   - FSM state type for the page-cross fixup sequencer
package ab_pkg;

  // Base select, op[3:2]
  localparam logic [1:0] AB_BASE_ZERO = 2'b00;
  localparam logic [1:0] AB_BASE_DB   = 2'b01;
  localparam logic [1:0] AB_BASE_HOLD = 2'b10;
  localparam logic [1:0] AB_BASE_PC   = 2'b11;

  // Offset select, op[1:0]; 01 behaves like 00 (no offset)
  localparam logic [1:0] AB_OFF_NONE  = 2'b00;
  localparam logic [1:0] AB_OFF_AB    = 2'b10;
  localparam logic [1:0] AB_OFF_REG   = 2'b11;

  typedef enum logic {
    AB_IDLE  = 1'b0,
    AB_FIXUP = 1'b1
  } ab_state_t;

endpackage

// File: rtl/ab_gen_if.sv
// ab_gen_if: bundle between the microcode decoder and the address generator.
//   master: decoder side (drives rdy, DB, REG, op, CI, fix_en, loads)
//   slave : ab_gen side (drives AD, AB, HOLD, PC, CO, pc_co, fixup)
interface ab_gen_if #(
  parameter int W = 16
);
  logic           rdy;
  logic [7:0]     DB;
  logic [7:0]     REG;
  logic [3:0]     op;
  logic           CI;
  logic           fix_en;
  logic [W/8-1:0] ld_hold;
  logic           ld_pc;
  logic           inc_pc;
  logic [W-1:0]   AD;
  logic [W-1:0]   AB;
  logic [W-1:0]   HOLD;
  logic [W-1:0]   PC;
  logic           CO;
  logic           pc_co;
  logic           fixup;

  modport master (
    output rdy, DB, REG, op, CI, fix_en, ld_hold, ld_pc, inc_pc,
    input  AD, AB, HOLD, PC, CO, pc_co, fixup
  );

  modport slave (
    input  rdy, DB, REG, op, CI, fix_en, ld_hold, ld_pc, inc_pc,
    output AD, AB, HOLD, PC, CO, pc_co, fixup
  );
endinterface

// File: rtl/ab_gen_add.sv
// ab_add: W-bit adder with the carry chain split at bit PAGE.
//   base, offset, ci : operands and carry-in
//   sum              : full W+1 bit result (sum[W] is the carry out)
//   page_co          : carry out of bit PAGE-1
//   sum_nc           : result whose upper part (bits W-1:PAGE) ignores page_co
module ab_add #(
  parameter int W    = 16,
  parameter int PAGE = 8
) (
  input  logic [W-1:0] base,
  input  logic [W-1:0] offset,
  input  logic         ci,
  output logic [W:0]   sum,
  output logic         page_co,
  output logic [W-1:0] sum_nc
);

  localparam logic [W-1:0] LO_MASK = (PAGE >= W) ? {W{1'b1}}
                                                 : ((W'(1) << PAGE) - W'(1));

  logic [PAGE:0] lo_s;

  // Full sum plus a separate low-page sum so the upper part can be formed without its carry
  always_comb begin
    sum     = {1'b0, base} + {1'b0, offset} + {{W{1'b0}}, ci};
    lo_s    = {1'b0, base[PAGE-1:0]} + {1'b0, offset[PAGE-1:0]} + {{PAGE{1'b0}}, ci};
    page_co = lo_s[PAGE];
    sum_nc  = ((base & ~LO_MASK) + (offset & ~LO_MASK)) | W'(lo_s[PAGE-1:0]);
  end

endmodule

// File: rtl/ab_gen.sv
// ab_gen: address-bus generator for the microcoded 65C02 core.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : ab_gen_if slave port (decoder inputs, address outputs)
// AD is the combinational next address, AB its registered copy. An indexed
// access (offset REG, fix_en) that carries across the page boundary emits the
// wrong-page address first, then a FIXUP cycle with the corrected upper part.
// rdy low freezes every register and parks AD on AB.
module ab_gen
  import ab_pkg::*;
#(
  parameter int W    = 16,
  parameter int PAGE = 8
) (
  input  logic clk,
  input  logic rst_n,
  ab_gen_if.slave bus
);

  localparam logic [W-1:0] LO_MASK = (PAGE >= W) ? {W{1'b1}}
                                                 : ((W'(1) << PAGE) - W'(1));

  ab_state_t    state_r, state_nxt_s;
  logic [W-1:0] ab_r, pc_r, hold_r, fix_hi_r;
  logic         fix_co_r;
  logic [W-1:0] base_s, off_s, ad_s, sum_nc_s;
  logic [W:0]   sum_s, pc_inc_s;
  logic         page_co_s, co_s, cross_s;

  // Base operand select
  always_comb begin
    base_s = '0;
    case (bus.op[3:2])
      AB_BASE_ZERO: base_s = '0;
      AB_BASE_DB:   base_s = W'(bus.DB);
      AB_BASE_HOLD: base_s = hold_r;
      AB_BASE_PC:   base_s = pc_r;
      default:      base_s = '0;
    endcase
  end

  // Offset operand select
  always_comb begin
    off_s = '0;
    case (bus.op[1:0])
      AB_OFF_AB:  off_s = ab_r;
      AB_OFF_REG: off_s = W'(bus.REG);
      default:    off_s = '0;
    endcase
  end

  ab_add #(.W(W), .PAGE(PAGE)) u_add (
    .base    (base_s),
    .offset  (off_s),
    .ci      (bus.CI),
    .sum     (sum_s),
    .page_co (page_co_s),
    .sum_nc  (sum_nc_s)
  );

  // Next state, next address and adder carry
  always_comb begin
    state_nxt_s = state_r;
    ad_s        = sum_s[W-1:0];
    co_s        = sum_s[W];
    cross_s     = 1'b0;
    if (!bus.rdy) begin
      ad_s = ab_r;
      co_s = 1'b0;
    end else begin
      case (state_r)
        AB_IDLE: begin
          if ((PAGE < W) && bus.fix_en && (bus.op[1:0] == AB_OFF_REG) && page_co_s) begin
            // Emit the wrong-page address now; the carry is applied next cycle
            cross_s     = 1'b1;
            ad_s        = sum_nc_s;
            co_s        = 1'b0;
            state_nxt_s = AB_FIXUP;
          end else begin
            ad_s = sum_s[W-1:0];
            co_s = sum_s[W];
          end
        end
        AB_FIXUP: begin
          ad_s        = (fix_hi_r & ~LO_MASK) | (ab_r & LO_MASK);
          co_s        = fix_co_r;
          state_nxt_s = AB_IDLE;
        end
        default: begin
          state_nxt_s = AB_IDLE;
        end
      endcase
    end
  end

  assign pc_inc_s = {1'b0, ab_r} + {{W{1'b0}}, bus.inc_pc};

  // State, address bus, fixup latch, hold and program counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= AB_IDLE;
      ab_r     <= '0;
      pc_r     <= '0;
      hold_r   <= '0;
      fix_hi_r <= '0;
      fix_co_r <= 1'b0;
    end else if (bus.rdy) begin
      state_r <= state_nxt_s;
      ab_r    <= ad_s;
      if (cross_s) begin
        fix_hi_r <= sum_s[W-1:0] & ~LO_MASK;
        fix_co_r <= sum_s[W];
      end
      // Loads are suppressed during the fixup cycle
      if (state_r == AB_IDLE) begin
        for (int k = 0; k < W/8; k++) begin
          if (bus.ld_hold[k]) hold_r[8*k +: 8] <= bus.DB;
        end
        if (bus.ld_pc) pc_r <= pc_inc_s[W-1:0];
      end
    end
  end

  assign bus.AD    = ad_s;
  assign bus.CO    = co_s;
  assign bus.AB    = ab_r;
  assign bus.PC    = pc_r;
  assign bus.HOLD  = hold_r;
  assign bus.pc_co = pc_inc_s[W];
  assign bus.fixup = (state_r == AB_FIXUP);

endmodule
